// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: radix-2 shift-add multiply sequencer for the EX stage.
// Ports: clk_i, rst_i (sync, active-low), start_i, flush_i, op_a_i, op_b_i
//        -> stall_o, busy_o, done_o, result_o (low WIDTH bits of a*b).
module mul_seq_ctrl #(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        stall_o  = 1'b0;
        done_o   = 1'b0;
        result_o = result_q;

        unique case (state_q)
            IDLE: begin
                if (start_i && !flush_i) begin
                    // Freeze EX already in the accept cycle.
                    stall_o  = 1'b1;
                    mcand_d  = op_a_i;
                    mplier_d = op_b_i;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    stall_o = 1'b1;
                    if (EARLY_OUT && mplier_q == '0) begin
                        state_d = DONE;
                    end else begin
                        if (mplier_q[0]) begin
                            acc_d = acc_q + mcand_q;
                        end
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                        count_d  = count_q + 1'b1;
                        if (count_q == CW'(WIDTH - 1)) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                // start_i here is still the mul leaving EX.
                state_d = IDLE;
                if (!flush_i) begin
                    done_o   = 1'b1;
                    result_o = acc_q;
                    result_d = acc_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o = (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed bench for mul_seq_ctrl.
// Instance 0 runs full-length, instance 1 uses early-out.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start [2];
    logic        flush [2];
    logic [31:0] opa   [2];
    logic [31:0] opb   [2];
    logic        stall [2];
    logic        busy  [2];
    logic        done  [2];
    logic [31:0] res   [2];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.WIDTH(32), .EARLY_OUT(1'b0)) u_dut0 (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start[0]),
        .flush_i  (flush[0]),
        .op_a_i   (opa[0]),
        .op_b_i   (opb[0]),
        .stall_o  (stall[0]),
        .busy_o   (busy[0]),
        .done_o   (done[0]),
        .result_o (res[0])
    );

    mul_seq_ctrl #(.WIDTH(32), .EARLY_OUT(1'b1)) u_dut1 (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start[1]),
        .flush_i  (flush[1]),
        .op_a_i   (opa[1]),
        .op_b_i   (opb[1]),
        .stall_o  (stall[1]),
        .busy_o   (busy[1]),
        .done_o   (done[1]),
        .result_o (res[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one mul on instance d and follow it to its done pulse.
    // With b2b set, return in the done cycle so the caller can
    // issue the next op on the very next edge.
    task automatic run_op(input int d,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [31:0] exp_res,
                          input int exp_stalls,
                          input bit b2b);
        int stalls = 0;
        int cyc    = 0;
        bit seen   = 1'b0;
        tick();
        start[d] = 1'b1;
        opa[d]   = a;
        opb[d]   = b;
        #1;
        chk("accept_stall", 32'(stall[d]), 32'd1);
        while (!seen && cyc < 80) begin
            if (done[d]) begin
                seen = 1'b1;
            end else begin
                if (stall[d]) stalls++;
                tick();
                start[d] = 1'b0;
                #1;
                cyc++;
            end
        end
        start[d] = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
        chk("done_no_stall", 32'(stall[d]), 32'd0);
        chk("done_result", res[d], exp_res);
        if (!b2b) begin
            tick();
            #1;
            chk("post_busy", 32'(busy[d]), 32'd0);
            chk("post_done", 32'(done[d]), 32'd0);
            chk("post_result", res[d], exp_res);
        end
    endtask

    initial begin
        int dones;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            flush[i] = 1'b0;
            opa[i]   = '0;
            opb[i]   = '0;
        end
        tick();
        tick();
        #1;
        chk("rst_stall0", 32'(stall[0]), 32'd0);
        chk("rst_busy0", 32'(busy[0]), 32'd0);
        chk("rst_done0", 32'(done[0]), 32'd0);
        chk("rst_res0", res[0], 32'd0);
        chk("rst_busy1", 32'(busy[1]), 32'd0);
        chk("rst_res1", res[1], 32'd0);
        rst = 1'b1;

        run_op(0, 32'd3, 32'd5, 32'd15, 33, 1'b0);
        run_op(1, 32'd3, 32'd5, 32'd15, 5, 1'b0);
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33, 1'b0);
        run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33, 1'b0);
        run_op(0, 32'h8000_0000, 32'd2, 32'd0, 33, 1'b0);
        run_op(1, 32'h8000_0000, 32'd2, 32'd0, 4, 1'b0);
        run_op(1, 32'd7, 32'd0, 32'd0, 2, 1'b0);
        run_op(1, 32'd7, 32'd4, 32'd28, 5, 1'b0);
        run_op(0, 32'd7, 32'd0, 32'd0, 33, 1'b0);

        // start with flush in IDLE is not accepted
        tick();
        start[1] = 1'b1;
        flush[1] = 1'b1;
        opa[1]   = 32'd9;
        opb[1]   = 32'd9;
        #1;
        chk("idle_flush_stall", 32'(stall[1]), 32'd0);
        tick();
        start[1] = 1'b0;
        flush[1] = 1'b0;
        #1;
        chk("idle_flush_busy", 32'(busy[1]), 32'd0);
        chk("idle_flush_res", res[1], 32'd28);

        // back-to-back: gap in stall is only the done cycle
        run_op(0, 32'd6, 32'd7, 32'd42, 33, 1'b1);
        run_op(0, 32'd9, 32'd9, 32'd81, 33, 1'b0);
        run_op(1, 32'd6, 32'd7, 32'd42, 5, 1'b1);
        run_op(1, 32'd9, 32'd9, 32'd81, 6, 1'b0);

        // flush in RUN cycle 10
        tick();
        start[0] = 1'b1;
        opa[0]   = 32'd100;
        opb[0]   = 32'd100;
        for (int k = 1; k < 10; k++) begin
            tick();
            start[0] = 1'b0;
        end
        tick();
        flush[0] = 1'b1;
        #1;
        chk("flush_stall", 32'(stall[0]), 32'd0);
        chk("flush_done", 32'(done[0]), 32'd0);
        chk("flush_busy", 32'(busy[0]), 32'd1);
        chk("flush_res", res[0], 32'd81);
        tick();
        flush[0] = 1'b0;
        #1;
        chk("after_flush_busy", 32'(busy[0]), 32'd0);
        chk("after_flush_stall", 32'(stall[0]), 32'd0);
        chk("after_flush_res", res[0], 32'd81);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done[0]) dones++;
        end
        chk("flush_no_done", 32'(dones), 32'd0);

        // reset in RUN cycle 5
        tick();
        start[0] = 1'b1;
        opa[0]   = 32'd3;
        opb[0]   = 32'd5;
        for (int k = 1; k < 5; k++) begin
            tick();
            start[0] = 1'b0;
        end
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", 32'(stall[0]), 32'd0);
        chk("mid_rst_busy", 32'(busy[0]), 32'd0);
        chk("mid_rst_done", 32'(done[0]), 32'd0);
        chk("mid_rst_res", res[0], 32'd0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done[0] || busy[0]) dones++;
        end
        chk("mid_rst_idle", 32'(dones), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
